// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - valid/ready command sequencer for the 4-bit combinational ALU
module alu_op_sequencer #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_a,
   input  logic [3:0] req_b,
   input  logic       req_c,
   input  logic [2:0] req_mode,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic       alu_c,
   output logic [2:0] alu_mode,
   input  logic [3:0] alu_r,
   input  logic       alu_ovf,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_r,
   output logic       rsp_ovf,
   input  logic       clr_counts,
   output logic [7:0] op_count,
   output logic [7:0] ovf_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

   state_t     state;
   state_t     state_nx;
   logic [3:0] settle_cnt;
   logic       accept;
   logic       capture;
   logic       handshake;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode plus the single-cycle accept/capture/handshake strobes
   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      capture   = 1'b0;
      handshake = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept   = 1'b1;
               state_nx = SETTLE;
            end
         end
         SETTLE: begin
            // <= 1 rather than == 1 so an out-of-range zero load cannot wedge the FSM
            if (settle_cnt <= 4'd1) begin
               capture  = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               handshake = 1'b1;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Settle countdown, loaded on acceptance and stepped every SETTLE edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= 4'd0;
      end else if (accept) begin
         settle_cnt <= SETTLE_LD;
      end else if (state == SETTLE && settle_cnt != 4'd0) begin
         settle_cnt <= settle_cnt - 4'd1;
      end
   end

   // ALU operand registers change only when a command is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a    <= 4'd0;
         alu_b    <= 4'd0;
         alu_c    <= 1'b0;
         alu_mode <= 3'd0;
      end else if (accept) begin
         alu_a    <= req_a;
         alu_b    <= req_b;
         alu_c    <= req_c;
         alu_mode <= req_mode;
      end
   end

   // Result capture after the settle window; held through backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_r   <= 4'd0;
         rsp_ovf <= 1'b0;
      end else if (capture) begin
         rsp_r   <= alu_r;
         rsp_ovf <= alu_ovf;
      end
   end

   // Completion counters: op count wraps, overflow count saturates, clear has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count  <= 8'd0;
         ovf_count <= 8'd0;
      end else if (clr_counts) begin
         op_count  <= 8'd0;
         ovf_count <= 8'd0;
      end else if (handshake) begin
         op_count <= op_count + 8'd1;
         if (rsp_ovf && ovf_count != 8'hFF) begin
            ovf_count <= ovf_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - bench for alu_op_sequencer with settle times 1 and 3
module tb_alu_op_sequencer;

   logic clk;
   logic rst_n;

   logic       req_valid1, req_ready1, req_c1, alu_c1, alu_ovf1, rsp_valid1, rsp_ready1, rsp_ovf1, clr_counts1;
   logic [3:0] req_a1, req_b1, alu_a1, alu_b1, alu_r1, rsp_r1;
   logic [2:0] req_mode1, alu_mode1;
   logic [7:0] op_count1, ovf_count1;
   logic       ovf_in1;

   logic       req_valid3, req_ready3, req_c3, alu_c3, alu_ovf3, rsp_valid3, rsp_ready3, rsp_ovf3, clr_counts3;
   logic [3:0] req_a3, req_b3, alu_a3, alu_b3, alu_r3, rsp_r3;
   logic [2:0] req_mode3, alu_mode3;
   logic [7:0] op_count3, ovf_count3;
   logic       ovf_in3;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       c;
      logic [2:0] m;
      logic       ov;
      logic [3:0] er;
   } vec_t;

   typedef struct packed {
      logic [3:0] r;
      logic       ov;
   } exp_t;

   vec_t vecs[8];
   exp_t sb[$];
   int   n_tests;
   int   n_fail;
   int   exp_ops;
   int   exp_ovfc;

   // bench ALU model: R = A ^ B ^ mode, overflow driven by the bench
   assign alu_r1   = alu_a1 ^ alu_b1 ^ {1'b0, alu_mode1};
   assign alu_ovf1 = ovf_in1;
   assign alu_r3   = alu_a3 ^ alu_b3 ^ {1'b0, alu_mode3};
   assign alu_ovf3 = ovf_in3;

   alu_op_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid1), .req_ready(req_ready1),
      .req_a(req_a1), .req_b(req_b1), .req_c(req_c1), .req_mode(req_mode1),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_c(alu_c1), .alu_mode(alu_mode1),
      .alu_r(alu_r1), .alu_ovf(alu_ovf1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_r(rsp_r1), .rsp_ovf(rsp_ovf1),
      .clr_counts(clr_counts1), .op_count(op_count1), .ovf_count(ovf_count1)
   );

   alu_op_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid3), .req_ready(req_ready3),
      .req_a(req_a3), .req_b(req_b3), .req_c(req_c3), .req_mode(req_mode3),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_c(alu_c3), .alu_mode(alu_mode3),
      .alu_r(alu_r3), .alu_ovf(alu_ovf3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_r(rsp_r3), .rsp_ovf(rsp_ovf3),
      .clr_counts(clr_counts3), .op_count(op_count3), .ovf_count(ovf_count3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every response handshake on the settle-1 instance pops one expectation
   always @(negedge clk) begin : sb_mon
      exp_t e;
      if (rst_n && rsp_valid1 && rsp_ready1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_rsp", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("rsp_r", {28'd0, rsp_r1}, {28'd0, e.r});
            chk("rsp_ovf", {31'd0, rsp_ovf1}, {31'd0, e.ov});
         end
      end
   end

   // one full command on the settle-1 instance, optionally clearing counters on the handshake
   task automatic do_cmd(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [2:0] m, input logic ov, input logic [3:0] er,
                         input logic clr);
      int   n;
      exp_t e;
      @(negedge clk);
      n = 0;
      while (!req_ready1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("req_ready_timeout", 0, 1);
      req_a1 = a; req_b1 = b; req_c1 = c; req_mode1 = m; ovf_in1 = ov;
      req_valid1 = 1'b1;
      e.r = er; e.ov = ov;
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid1 = 1'b0;
      chk("alu_a", {28'd0, alu_a1}, {28'd0, a});
      chk("alu_b", {28'd0, alu_b1}, {28'd0, b});
      chk("alu_c", {31'd0, alu_c1}, {31'd0, c});
      chk("alu_mode", {29'd0, alu_mode1}, {29'd0, m});
      chk("req_ready_busy", {31'd0, req_ready1}, 0);
      n = 0;
      while (!rsp_valid1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency1", n, 1);
      if (clr) clr_counts1 = 1'b1;
      @(posedge clk); #1;
      if (clr) begin
         clr_counts1 = 1'b0;
         exp_ops  = 0;
         exp_ovfc = 0;
      end else begin
         exp_ops = (exp_ops + 1) % 256;
         if (ov) exp_ovfc = (exp_ovfc == 255) ? 255 : exp_ovfc + 1;
      end
      chk("rsp_valid_drop", {31'd0, rsp_valid1}, 0);
      chk("op_count", {24'd0, op_count1}, exp_ops);
      chk("ovf_count", {24'd0, ovf_count1}, exp_ovfc);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin : main
      int n;
      n_tests = 0; n_fail = 0; exp_ops = 0; exp_ovfc = 0;
      vecs[0] = '{a: 4'h5, b: 4'hA, c: 1'b1, m: 3'd0, ov: 1'b0, er: 4'hF};
      vecs[1] = '{a: 4'h3, b: 4'h3, c: 1'b0, m: 3'd1, ov: 1'b0, er: 4'h1};
      vecs[2] = '{a: 4'hF, b: 4'h0, c: 1'b1, m: 3'd2, ov: 1'b1, er: 4'hD};
      vecs[3] = '{a: 4'h6, b: 4'h9, c: 1'b0, m: 3'd3, ov: 1'b0, er: 4'hC};
      vecs[4] = '{a: 4'h8, b: 4'h1, c: 1'b1, m: 3'd4, ov: 1'b1, er: 4'hD};
      vecs[5] = '{a: 4'hC, b: 4'h4, c: 1'b0, m: 3'd5, ov: 1'b0, er: 4'hD};
      vecs[6] = '{a: 4'h7, b: 4'h7, c: 1'b1, m: 3'd6, ov: 1'b1, er: 4'h6};
      vecs[7] = '{a: 4'hA, b: 4'h5, c: 1'b0, m: 3'd7, ov: 1'b0, er: 4'h8};

      rst_n = 1'b0;
      req_valid1 = 0; req_a1 = 0; req_b1 = 0; req_c1 = 0; req_mode1 = 0; rsp_ready1 = 1; clr_counts1 = 0; ovf_in1 = 0;
      req_valid3 = 0; req_a3 = 0; req_b3 = 0; req_c3 = 0; req_mode3 = 0; rsp_ready3 = 0; clr_counts3 = 0; ovf_in3 = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset values
      chk("rst_req_ready", {31'd0, req_ready1}, 1);
      chk("rst_rsp_valid", {31'd0, rsp_valid1}, 0);
      chk("rst_alu", {20'd0, alu_a1, alu_b1, alu_c1, alu_mode1}, 0);
      chk("rst_rsp", {27'd0, rsp_r1, rsp_ovf1}, 0);
      chk("rst_counts", {16'd0, op_count1, ovf_count1}, 0);
      chk("rst_req_ready3", {31'd0, req_ready3}, 1);
      chk("rst_rsp_valid3", {31'd0, rsp_valid3}, 0);

      // single command then all eight modes back to back
      for (int i = 0; i < 8; i++) begin
         do_cmd(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].m, vecs[i].ov, vecs[i].er, 1'b0);
      end
      chk("op_count_after_modes", {24'd0, op_count1}, 8);
      chk("ovf_count_after_modes", {24'd0, ovf_count1}, 3);

      // counter boundaries
      @(negedge clk);
      clr_counts1 = 1'b1;
      @(posedge clk); #1;
      clr_counts1 = 1'b0;
      exp_ops = 0; exp_ovfc = 0;
      chk("clr_idle", {16'd0, op_count1, ovf_count1}, 0);
      for (int i = 0; i < 256; i++) begin
         do_cmd(4'(i), 4'h3, 1'b0, 3'(i), 1'b1, 4'(i) ^ 4'h3 ^ {1'b0, 3'(i)}, 1'b0);
      end
      chk("op_count_wrap", {24'd0, op_count1}, 0);
      chk("ovf_count_sat", {24'd0, ovf_count1}, 255);
      do_cmd(4'h2, 4'h2, 1'b1, 3'd1, 1'b1, 4'h1, 1'b1);
      chk("clr_on_handshake", {16'd0, op_count1, ovf_count1}, 0);

      // backpressure on the settle-3 instance
      @(negedge clk);
      req_a3 = 4'h3; req_b3 = 4'h9; req_c3 = 1'b0; req_mode3 = 3'd5; req_valid3 = 1'b1; ovf_in3 = 1'b1;
      @(posedge clk); #1;
      chk("bp_alu_a", {28'd0, alu_a3}, 3);
      chk("bp_alu_mode", {29'd0, alu_mode3}, 5);
      req_a3 = 4'hC;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         chk("bp_latency", {31'd0, rsp_valid3}, (k == 3) ? 1 : 0);
      end
      chk("bp_rsp_r", {28'd0, rsp_r3}, 4'hF);
      chk("bp_rsp_ovf", {31'd0, rsp_ovf3}, 1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", {31'd0, rsp_valid3}, 1);
         chk("bp_hold_r", {28'd0, rsp_r3}, 4'hF);
         chk("bp_req_ready", {31'd0, req_ready3}, 0);
         chk("bp_alu_hold", {28'd0, alu_a3}, 3);
      end
      rsp_ready3 = 1'b1;
      @(posedge clk); #1;
      chk("bp_done_valid", {31'd0, rsp_valid3}, 0);
      chk("bp_no_accept_resp", {28'd0, alu_a3}, 3);
      chk("bp_req_ready_idle", {31'd0, req_ready3}, 1);
      chk("bp_op_count", {24'd0, op_count3}, 1);
      chk("bp_ovf_count", {24'd0, ovf_count3}, 1);
      req_valid3 = 1'b0;
      rsp_ready3 = 1'b0;

      // reset in the middle of SETTLE
      @(negedge clk);
      req_a3 = 4'h6; req_b3 = 4'h1; req_mode3 = 3'd2; req_valid3 = 1'b1; ovf_in3 = 1'b0;
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req_ready", {31'd0, req_ready3}, 1);
      chk("mid_rst_rsp_valid", {31'd0, rsp_valid3}, 0);
      chk("mid_rst_alu_a", {28'd0, alu_a3}, 0);
      chk("mid_rst_op_count", {24'd0, op_count3}, 0);
      exp_ops = 0; exp_ovfc = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rsp_ready3 = 1'b1;
      n = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (rsp_valid3) n++;
      end
      chk("mid_rst_no_rsp", n, 0);
      @(negedge clk);
      req_a3 = 4'h1; req_b3 = 4'h2; req_mode3 = 3'd0; req_valid3 = 1'b1;
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      n = 0;
      while (!rsp_valid3 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("post_rst_latency3", n, 3);
      chk("post_rst_rsp_r3", {28'd0, rsp_r3}, 3);
      @(posedge clk); #1;
      chk("post_rst_op_count3", {24'd0, op_count3}, 1);
      do_cmd(4'h9, 4'h6, 1'b1, 3'd3, 1'b0, 4'hC, 1'b0);

      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential front end for the combinational 4-bit ALU (`fourBitAlu`). It accepts ALU commands (operands, carry-in, mode) over a valid/ready request channel and drives them onto the ALU inputs. It waits a programmable settle time, captures the result and overflow flag, and returns them over a valid/ready response channel. It also keeps operation and overflow counters, so the ALU can be driven from a controller instead of a testbench.

## Interface
- `SETTLE_CYCLES`, default 1: clock edges between command acceptance and result capture; legal range 1..15.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  command present
- `req_ready`  out  1  sequencer can accept a command
- `req_a`, `req_b`  in  4 each  operands
- `req_c`  in  1  carry-in
- `req_mode`  in  3  ALU mode (000..111, passed through unchanged)
- `alu_a`, `alu_b`  out  4 each  registered operands to ALU A, B
- `alu_c`  out  1  registered carry-in to ALU C
- `alu_mode`  out  3  registered mode to ALU Mode
- `alu_r`  in  4  ALU result R
- `alu_ovf`  in  1  ALU overFlow
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer takes result
- `rsp_r`  out  4  captured result
- `rsp_ovf`  out  1  captured overflow
- `clr_counts`  in  1  synchronous counter clear
- `op_count`  out  8  completed responses, wrapping
- `ovf_count`  out  8  completed responses with `rsp_ovf=1`, saturating

## Operation
- FSM states: IDLE, SETTLE, RESP. Reset state is IDLE.
- `req_ready = (state == IDLE)`, decoded from state only. `rsp_valid = (state == RESP)`.
- **IDLE:** on `req_valid`, the sequencer:
  - latches `req_*` into `alu_*`;
  - loads the 4-bit settle counter with `SETTLE_CYCLES`;
  - moves to SETTLE.
- **SETTLE:** the counter decrements each edge. On the edge where the counter equals 1, the sequencer samples `alu_r` and `alu_ovf` into `rsp_r` and `rsp_ovf`, then moves to RESP.
- **RESP:** `rsp_r` and `rsp_ovf` hold until `rsp_valid && rsp_ready`, then the FSM returns to IDLE.
- `alu_*` hold their last values in every state. They change only on request acceptance.
- No new request is accepted in RESP, even on the handshake cycle. The next acceptance is at the earliest one cycle after return to IDLE.
- **Counters:** on each response handshake:
  - `op_count` increments, wrapping 255→0;
  - `ovf_count` increments if `rsp_ovf=1`, holding at 255.
- `clr_counts` zeroes both counters. Clear wins over a same-cycle increment.
- The sequencer does not interpret `req_mode`. All 8 modes behave identically.
- **Reset (any time, including mid-SETTLE or RESP):** immediately forces IDLE and the following values. Any in-flight command is dropped without a response.
  - `alu_a`, `alu_b`, `alu_mode`, `rsp_r`, settle counter = 0;
  - `alu_c`, `rsp_ovf`, `rsp_valid` = 0;
  - `op_count`, `ovf_count` = 0;
  - `req_ready` = 1.

## Timing
- **Acceptance:** the edge T where `req_valid && req_ready`. `alu_*` are valid after edge T.
- **Capture:** at edge T+`SETTLE_CYCLES`. `rsp_valid` is high from then until the handshake edge.
- **Latency:** `SETTLE_CYCLES` edges from acceptance to `rsp_valid`.
- **Back-to-back throughput:** with `rsp_ready` held high, one command per `SETTLE_CYCLES`+2 cycles.
- `rsp_r`, `rsp_ovf`, `rsp_valid`, `alu_*` and both counters are all registered.
- `req_*` are ignored outside IDLE. `rsp_ready` is ignored outside RESP.

## Test plan
- **Reset values:** assert `rst_n=0`, then release. All outputs are zero except `req_ready=1`.
- **Single command:** `SETTLE_CYCLES=1`, bench ALU model `R=A^B`, `ovf=0`. Send A=0101, B=1010, C=1, Mode=000.
  - `alu_a=0101` and `alu_c=1` one edge later.
  - `rsp_valid` with `rsp_r=1111`, `rsp_ovf=0` at T+1.
  - `op_count=1` after the handshake.
- **Response backpressure:** `SETTLE_CYCLES=3`, ALU model `ovf=1`. Hold `rsp_ready=0` for 5 cycles.
  - `rsp_valid` rises at T+3 and `rsp_r` stays stable.
  - `req_ready` stays 0 despite `req_valid=1`.
  - After the handshake, `ovf_count=1`.
- **All modes:** send 8 commands with Mode 000..111 back-to-back. Each `alu_mode` matches its request, and `op_count=8`.
- **Counter boundaries:** drive 256 handshakes with `ovf=1`; `op_count` wraps to 0 and `ovf_count` holds at 255. Assert `clr_counts` on a handshake cycle; both counters read 0.
- **Reset mid-operation:** pull `rst_n` low in SETTLE.
  - FSM returns to IDLE asynchronously and `rsp_valid` never asserts.
  - After release, a new command completes normally.
